// File: rtl/grf_pkg.sv
// Shared definitions for the general register file (W-stage writer, D-stage reader).
// Holds the register-file geometry, the hardwired-zero register index, the reset
// value of every storage element, and the commit qualifier shared by the array
// and the read bypass.
package grf_pkg;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CNT_W = 32;

  localparam logic [AW-1:0] REG_ZERO  = 5'd0;
  localparam logic [DW-1:0] RESET_VAL = 32'h0;

  // A write commits only when enabled, not aimed at r0, and not under reset.
  function automatic logic is_commit(input logic we, input logic [AW-1:0] a3,
                                     input logic rst);
    return we && (a3 != REG_ZERO) && !rst;
  endfunction

endpackage

// File: rtl/grf_bypass_mux.sv
// Read-port selector for one D-stage read port.
// Ports:
//   addr  - D-stage read address
//   we    - write is committing this cycle (already qualified: enabled, A3!=0, no reset)
//   a3    - W-stage destination register
//   wd    - W-stage write-back data
//   word  - current array contents at addr
//   reset - synchronous reset of the register file; forces the read to zero
//   rd    - read data: 0 for r0 or during reset, else bypassed WD, else array word
module grf_bypass_mux
  import grf_pkg::*;
(
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [AW-1:0] a3,
  input  logic [DW-1:0] wd,
  input  logic [DW-1:0] word,
  input  logic          reset,
  output logic [DW-1:0] rd
);

  // Priority select: reset, then hardwired zero, then same-cycle bypass, then array.
  always_comb begin
    rd = RESET_VAL;
    if (reset) begin
      rd = RESET_VAL;
    end else if (addr == REG_ZERO) begin
      rd = RESET_VAL;
    end else if (we && (a3 == addr)) begin
      rd = wd;
    end else begin
      rd = word;
    end
  end

endmodule

// File: rtl/grf_d_read.sv
// General register file between the W stage (writer) and the D stage (reader).
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   A1_D, A2_D            - D-stage read addresses (rs, rt)
//   RD1_D, RD2_D          - combinational read data with W->D bypass
//   RegWrite_W, A3_W      - W-stage write enable and destination
//   WD_W, PC_W            - W-stage write-back data and instruction PC
//   TraceValid            - high for one cycle after each committed write
//   TracePC/Addr/Data     - PC, destination and data of the last committed write
//   CommitCount           - committed writes since reset, wrapping
module grf_d_read
  import grf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    A1_D,
  input  logic [AW-1:0]    A2_D,
  output logic [DW-1:0]    RD1_D,
  output logic [DW-1:0]    RD2_D,
  input  logic             RegWrite_W,
  input  logic [AW-1:0]    A3_W,
  input  logic [DW-1:0]    WD_W,
  input  logic [31:0]      PC_W,
  output logic             TraceValid,
  output logic [31:0]      TracePC,
  output logic [AW-1:0]    TraceAddr,
  output logic [DW-1:0]    TraceData,
  output logic [CNT_W-1:0] CommitCount
);

  logic [DW-1:0]    regs_r [NREG];
  logic             trace_valid_r;
  logic [31:0]      trace_pc_r;
  logic [AW-1:0]    trace_addr_r;
  logic [DW-1:0]    trace_data_r;
  logic [CNT_W-1:0] commit_count_r;
  logic             commit_s;

  assign commit_s = is_commit(RegWrite_W, A3_W, reset);

  grf_bypass_mux u_rd1 (
    .addr  (A1_D),
    .we    (commit_s),
    .a3    (A3_W),
    .wd    (WD_W),
    .word  (regs_r[A1_D]),
    .reset (reset),
    .rd    (RD1_D)
  );

  grf_bypass_mux u_rd2 (
    .addr  (A2_D),
    .we    (commit_s),
    .a3    (A3_W),
    .wd    (WD_W),
    .word  (regs_r[A2_D]),
    .reset (reset),
    .rd    (RD2_D)
  );

  // Register array, commit trace and commit counter; reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= RESET_VAL;
      end
      trace_valid_r  <= 1'b0;
      trace_pc_r     <= 32'h0;
      trace_addr_r   <= REG_ZERO;
      trace_data_r   <= RESET_VAL;
      commit_count_r <= '0;
    end else if (commit_s) begin
      regs_r[A3_W]   <= WD_W;
      trace_valid_r  <= 1'b1;
      trace_pc_r     <= PC_W;
      trace_addr_r   <= A3_W;
      trace_data_r   <= WD_W;
      commit_count_r <= commit_count_r + CNT_W'(1);
    end else begin
      // Non-commit edge: only the valid pulse drops, the last commit stays visible.
      trace_valid_r  <= 1'b0;
    end
  end

  assign TraceValid  = trace_valid_r;
  assign TracePC     = trace_pc_r;
  assign TraceAddr   = trace_addr_r;
  assign TraceData   = trace_data_r;
  assign CommitCount = commit_count_r;

endmodule

// File: tb/tb_grf_d_read.sv
// Self-checking bench for grf_d_read: directed scenarios followed by randomized
// traffic, compared against a behavioural register-file model.
module tb_grf_d_read;

  logic        clk;
  logic        reset;
  logic [4:0]  A1_D, A2_D, A3_W, TraceAddr;
  logic [31:0] RD1_D, RD2_D, WD_W, PC_W, TracePC, TraceData, CommitCount;
  logic        RegWrite_W, TraceValid;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_tvalid;
  logic [31:0] m_tpc;
  logic [4:0]  m_taddr;
  logic [31:0] m_tdata;
  logic [31:0] m_count;

  grf_d_read dut (
    .clk         (clk),
    .reset       (reset),
    .A1_D        (A1_D),
    .A2_D        (A2_D),
    .RD1_D       (RD1_D),
    .RD2_D       (RD2_D),
    .RegWrite_W  (RegWrite_W),
    .A3_W        (A3_W),
    .WD_W        (WD_W),
    .PC_W        (PC_W),
    .TraceValid  (TraceValid),
    .TracePC     (TracePC),
    .TraceAddr   (TraceAddr),
    .TraceData   (TraceData),
    .CommitCount (CommitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rst, input logic we,
                                             input logic [4:0] a, input logic [4:0] a3,
                                             input logic [31:0] wd);
    if (rst || a == 5'd0) return 32'h0;
    if (we && a3 == a) return wd;
    return m_regs[a];
  endfunction

  // One clock cycle: drive, check reads before the edge, update model, check state after.
  task automatic step(input logic rst, input logic we, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] a3,
                      input logic [31:0] wd, input logic [31:0] pc);
    @(negedge clk);
    reset = rst; RegWrite_W = we; A1_D = a1; A2_D = a2; A3_W = a3; WD_W = wd; PC_W = pc;
    #1;
    check("rd1", RD1_D, model_read(rst, we, a1, a3, wd));
    check("rd2", RD2_D, model_read(rst, we, a2, a3, wd));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_tvalid = 1'b0; m_tpc = 32'h0; m_taddr = 5'd0; m_tdata = 32'h0; m_count = 32'h0;
    end else if (we && a3 != 5'd0) begin
      m_regs[a3] = wd;
      m_tvalid = 1'b1; m_tpc = pc; m_taddr = a3; m_tdata = wd;
      m_count = m_count + 32'd1;
    end else begin
      m_tvalid = 1'b0;
    end
    #1;
    check("trace_valid", {31'd0, TraceValid}, {31'd0, m_tvalid});
    check("trace_pc", TracePC, m_tpc);
    check("trace_addr", {27'd0, TraceAddr}, {27'd0, m_taddr});
    check("trace_data", TraceData, m_tdata);
    check("commit_count", CommitCount, m_count);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_tvalid = 1'b0; m_tpc = 32'h0; m_taddr = 5'd0; m_tdata = 32'h0; m_count = 32'h0;
    reset = 1'b1; RegWrite_W = 1'b0; A1_D = 5'd0; A2_D = 5'd0; A3_W = 5'd0;
    WD_W = 32'h0; PC_W = 32'h0;

    // 1. reset for two cycles, then unwritten registers read zero
    step(1'b1, 1'b0, 5'd7, 5'd31, 5'd0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 5'd7, 5'd31, 5'd0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 5'd7, 5'd31, 5'd0, 32'h0, 32'h0);
    check("t1_rd1_zero", RD1_D, 32'h0);
    // 2. bypass then array read
    step(1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 32'h12345678, 32'h3000);
    check("t2_trace_addr", {27'd0, TraceAddr}, 32'd8);
    check("t2_count", CommitCount, 32'd1);
    step(1'b0, 1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0);
    // 3. write to r0 is discarded
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h3004);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("t3_count", CommitCount, 32'd1);
    // 4. dual bypass, then no bypass without enable
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 32'hAAAA5555, 32'h3008);
    step(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 32'h1, 32'h300C);
    check("t4_rd1_hold", RD1_D, 32'hAAAA5555);
    // 5. reset wins over a simultaneous write
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'hDEAD, 32'h3010);
    step(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0);
    // 6. back-to-back commits then an idle cycle
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 5'(i), 5'(i), 5'(i), $urandom, 32'h3000 + 32'(4 * (i - 1)));
    check("t6_trace_pc", TracePC, 32'h3010);
    check("t6_count", CommitCount, 32'd5);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("t6_addr_hold", {27'd0, TraceAddr}, 32'd5);

    // Randomized traffic with biased address collisions and rare resets
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, a3;
      logic we, rst;
      a3  = 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      we  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      step(rst, we, a1, a2, a3, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
